// File: rtl/min_sec_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package min_sec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SET  = 2'd2
  } state_e;

  localparam int unsigned DIGIT_MAX_UNITS = 9;
  localparam int unsigned DIGIT_MAX_TENS  = 5;

  localparam logic [1:0] SEL_SEC_1  = 2'd0;
  localparam logic [1:0] SEL_SEC_10 = 2'd1;
  localparam logic [1:0] SEL_MIN_1  = 2'd2;
  localparam logic [1:0] SEL_MIN_10 = 2'd3;

  // Anything at or above the limit (including illegal codes) rolls to 0.
  function automatic logic [3:0] bcd_inc(input logic [3:0] q, input logic [3:0] max);
    return (q >= max) ? 4'd0 : q + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register counting 0..MAX with synchronous clear and a carry-out.
module bcd_digit
  import min_sec_pkg::*;
#(
  parameter int unsigned MAX = DIGIT_MAX_UNITS
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [3:0] q_o,
  output logic       carry_o
);

  localparam logic [3:0] MaxQ = 4'(MAX);

  logic [3:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 4'd0;
    end else if (inc_i) begin
      q_d = bcd_inc(q_q, MaxQ);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o     = q_q;
  assign carry_o = inc_i && (q_q == MaxQ);

endmodule

// File: rtl/min_sec_counter.sv
// MM:SS stopwatch core: prescaled 1 s tick, four BCD digits, start/stop/clear and manual set.
// Optional lap snapshot register enabled by defining MIN_SEC_COUNTER_LAP_EN.
module min_sec_counter
  import min_sec_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START_STOP,
  input  logic       CLEAR,
  input  logic       SET_MODE,
  input  logic [1:0] SET_SEL,
  input  logic       SET_INC,
`ifdef MIN_SEC_COUNTER_LAP_EN
  input  logic       LAP,
  output logic [15:0] LAP_DIGITS,
`endif
  output logic [3:0] SEC_1,
  output logic [3:0] SEC_10,
  output logic [3:0] MIN_1,
  output logic [3:0] MIN_10,
  output logic       RUNNING,
  output logic       WRAP
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TickMax = PW'(TICK_DIV - 1);

  state_e state_d, state_q;
  logic [PW-1:0] presc_d, presc_q;
  logic wrap_d, wrap_q;
  logic tick;
  logic [3:0] set_inc;
  logic [3:0] inc;
  logic [3:0] carry;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!CLEAR) begin
      unique case (state_q)
        ST_IDLE: begin
          if (SET_MODE) state_d = ST_SET;
          else if (START_STOP) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (SET_MODE) state_d = ST_SET;
          else if (START_STOP) state_d = ST_IDLE;
        end
        ST_SET: begin
          if (!SET_MODE) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    RUNNING = (state_q == ST_RUN);
  end

  // ---------------- Prescaler ----------------
  // Held outside RUN so a stop/start resumes on the same phase.
  assign tick = (state_q == ST_RUN) && (presc_q == TickMax) && !CLEAR;

  always_comb begin
    presc_d = presc_q;
    if (CLEAR) begin
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = (presc_q == TickMax) ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------- Digits ----------------
  always_comb begin
    set_inc = 4'b0000;
    if (state_q == ST_SET && SET_INC) begin
      unique case (SET_SEL)
        SEL_SEC_1:  set_inc = 4'b0001;
        SEL_SEC_10: set_inc = 4'b0010;
        SEL_MIN_1:  set_inc = 4'b0100;
        SEL_MIN_10: set_inc = 4'b1000;
        default:    set_inc = 4'b0000;
      endcase
    end
  end

  // Carries only ripple on a real tick; manual edits never touch neighbours.
  assign inc[0] = tick | set_inc[0];
  assign inc[1] = (carry[0] & tick) | set_inc[1];
  assign inc[2] = (carry[1] & tick) | set_inc[2];
  assign inc[3] = (carry[2] & tick) | set_inc[3];

  bcd_digit #(.MAX(DIGIT_MAX_UNITS)) u_sec_1 (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .inc_i   (inc[0]),
    .clr_i   (CLEAR),
    .q_o     (SEC_1),
    .carry_o (carry[0])
  );

  bcd_digit #(.MAX(DIGIT_MAX_TENS)) u_sec_10 (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .inc_i   (inc[1]),
    .clr_i   (CLEAR),
    .q_o     (SEC_10),
    .carry_o (carry[1])
  );

  bcd_digit #(.MAX(DIGIT_MAX_UNITS)) u_min_1 (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .inc_i   (inc[2]),
    .clr_i   (CLEAR),
    .q_o     (MIN_1),
    .carry_o (carry[2])
  );

  bcd_digit #(.MAX(DIGIT_MAX_TENS)) u_min_10 (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .inc_i   (inc[3]),
    .clr_i   (CLEAR),
    .q_o     (MIN_10),
    .carry_o (carry[3])
  );

  // Registered so the pulse lines up with 00:00 becoming visible.
  assign wrap_d = tick & carry[3];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign WRAP = wrap_q;

`ifdef MIN_SEC_COUNTER_LAP_EN
  logic [15:0] lap_d, lap_q;

  always_comb begin
    lap_d = lap_q;
    if (CLEAR) begin
      lap_d = 16'h0000;
    end else if (LAP && state_q == ST_RUN) begin
      lap_d = {MIN_10, MIN_1, SEC_10, SEC_1};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lap_q <= 16'h0000;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign LAP_DIGITS = lap_q;
`endif

endmodule

// File: tb/tb_min_sec_counter.sv
// Self-checking bench for min_sec_counter (TICK_DIV=4): directed vectors plus a
// randomized run against a seconds-based reference model.
module tb_min_sec_counter;

  localparam int unsigned TickDiv = 4;
  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MSet  = 2;

  logic       clk;
  logic       rst_n;
  logic       start_stop;
  logic       clear;
  logic       set_mode;
  logic [1:0] set_sel;
  logic       set_inc;
  logic       lap;
  logic [3:0] sec_1, sec_10, min_1, min_10;
  logic       running, wrap;
  logic [15:0] lap_digits;
  logic [15:0] digits;

  assign digits = {min_10, min_1, sec_10, sec_1};

  min_sec_counter #(.TICK_DIV(TickDiv)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .START_STOP (start_stop),
    .CLEAR      (clear),
    .SET_MODE   (set_mode),
    .SET_SEL    (set_sel),
    .SET_INC    (set_inc),
`ifdef MIN_SEC_COUNTER_LAP_EN
    .LAP        (lap),
    .LAP_DIGITS (lap_digits),
`endif
    .SEC_1      (sec_1),
    .SEC_10     (sec_10),
    .MIN_1      (min_1),
    .MIN_10     (min_10),
    .RUNNING    (running),
    .WRAP       (wrap)
  );

`ifndef MIN_SEC_COUNTER_LAP_EN
  assign lap_digits = 16'h0000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: elapsed time kept as plain seconds 0..3599.
  int m_state = MIdle;
  int m_ph    = 0;
  int m_secs  = 0;
  bit m_wrap  = 1'b0;
  logic [15:0] m_lap = 16'h0000;

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int edit_digit(input int secs, input int sel);
    int d[4];
    int lim[4];
    lim = '{10, 6, 10, 6};
    d[0] = (secs % 60) % 10;
    d[1] = (secs % 60) / 10;
    d[2] = (secs / 60) % 10;
    d[3] = (secs / 60) / 10;
    d[sel] = (d[sel] + 1) % lim[sel];
    return (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
  endfunction

  task automatic model_edge(input logic ss, input logic clr, input logic sm,
                            input logic [1:0] sel, input logic inc, input logic lp);
    logic [15:0] old;
    old = to_bcd(m_secs);
    m_wrap = 1'b0;
    if (clr) begin
      m_secs = 0;
      m_ph   = 0;
      m_lap  = 16'h0000;
    end else begin
      if (m_state == MRun) begin
        if (lp) m_lap = old;
        if (m_ph == TickDiv - 1) begin
          m_ph = 0;
          if (m_secs == 3599) begin
            m_secs = 0;
            m_wrap = 1'b1;
          end else begin
            m_secs = m_secs + 1;
          end
        end else begin
          m_ph = m_ph + 1;
        end
      end
      if (m_state == MSet && inc) m_secs = edit_digit(m_secs, int'(sel));
      case (m_state)
        MIdle:   m_state = sm ? MSet : (ss ? MRun : MIdle);
        MRun:    m_state = sm ? MSet : (ss ? MIdle : MRun);
        default: m_state = sm ? MSet : MIdle;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, advance model, compare at next negedge.
  task automatic step(input logic ss, input logic clr, input logic sm,
                      input logic [1:0] sel, input logic inc, input logic lp);
    start_stop = ss;
    clear      = clr;
    set_mode   = sm;
    set_sel    = sel;
    set_inc    = inc;
    lap        = lp;
    @(posedge clk);
    model_edge(ss, clr, sm, sel, inc, lp);
    @(negedge clk);
    chk("model", {14'd0, digits, running, wrap},
        {14'd0, to_bcd(m_secs), (m_state == MRun), m_wrap});
`ifdef MIN_SEC_COUNTER_LAP_EN
    chk("model_lap", {16'd0, lap_digits}, {16'd0, m_lap});
`endif
    start_stop = 1'b0;
    clear      = 1'b0;
    set_inc    = 1'b0;
    lap        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic set_incs(input logic [1:0] sel, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, sel, 1'b1, 1'b0);
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_ph    = 0;
    m_secs  = 0;
    m_wrap  = 1'b0;
    m_lap   = 16'h0000;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        inc;
    logic [15:0] exp_digits;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic sm_lvl;
    vecs[0] = '{2'd1, 1'b1, 16'h0011};
    vecs[1] = '{2'd1, 1'b1, 16'h0021};
    vecs[2] = '{2'd1, 1'b1, 16'h0031};
    vecs[3] = '{2'd1, 1'b1, 16'h0041};
    vecs[4] = '{2'd1, 1'b1, 16'h0051};
    vecs[5] = '{2'd1, 1'b1, 16'h0001};
    vecs[6] = '{2'd1, 1'b1, 16'h0011};

    rst_n = 1'b0; start_stop = 1'b0; clear = 1'b0; set_mode = 1'b0;
    set_sel = 2'd0; set_inc = 1'b0; lap = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_digits", {16'd0, digits}, 32'h0);
    chk("reset_running", {31'd0, running}, 32'h0);
    chk("reset_wrap", {31'd0, wrap}, 32'h0);
    chk("reset_lap", {16'd0, lap_digits}, 32'h0);
    rst_n = 1'b1;
    model_reset();

    // 1: run 40 cycles, one second every 4 cycles
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      idle(4);
      chk("t1_sec_1", {28'd0, sec_1}, 32'(k % 10));
      chk("t1_running", {31'd0, running}, 32'h1);
    end
    chk("t1_time", {16'd0, digits}, 32'h0010);

    // 2: preload 59:58 and roll over
    step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    set_incs(2'd3, 5);
    set_incs(2'd2, 9);
    set_incs(2'd1, 5);
    set_incs(2'd0, 8);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t2_preload", {16'd0, digits}, 32'h5958);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(4);
    chk("t2_5959", {16'd0, digits}, 32'h5959);
    idle(3);
    chk("t2_no_early_wrap", {31'd0, wrap}, 32'h0);
    idle(1);
    chk("t2_zero", {16'd0, digits}, 32'h0000);
    chk("t2_wrap", {31'd0, wrap}, 32'h1);
    idle(1);
    chk("t2_wrap_pulse", {31'd0, wrap}, 32'h0);

    // 3: stop mid-phase, resume, first tick lands on held phase
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(20);
    chk("t3_stopped", {31'd0, running}, 32'h0);
    chk("t3_held", {16'd0, digits}, 32'h0000);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(1);
    chk("t3_pre_tick", {16'd0, digits}, 32'h0000);
    idle(1);
    chk("t3_tick", {16'd0, digits}, 32'h0001);

    // 4: SEC_10 manual increments, no carry, no wrap
    step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    chk("t4_in_set", {31'd0, running}, 32'h0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, vecs[i].sel, vecs[i].inc, 1'b0);
      chk($sformatf("t4_vec%0d", i), {16'd0, digits}, {16'd0, vecs[i].exp_digits});
      chk("t4_wrap", {31'd0, wrap}, 32'h0);
    end

    // 5: CLEAR on a tick at 12:34, then async reset mid-run
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    set_incs(2'd3, 1);
    set_incs(2'd2, 2);
    set_incs(2'd1, 3);
    set_incs(2'd0, 4);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t5_preload", {16'd0, digits}, 32'h1234);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(3);
    chk("t5_before", {16'd0, digits}, 32'h1234);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t5_cleared", {16'd0, digits}, 32'h0000);
    chk("t5_running", {31'd0, running}, 32'h1);
    chk("t5_no_wrap", {31'd0, wrap}, 32'h0);
    idle(9);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_digits", {16'd0, digits}, 32'h0);
    chk("t5_async_running", {31'd0, running}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MIN_SEC_COUNTER_LAP_EN
    // 6: lap snapshot
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(28);
    chk("t6_time", {16'd0, digits}, 32'h0007);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("t6_lap", {16'd0, lap_digits}, 32'h0007);
    idle(4);
    chk("t6_continue", {16'd0, digits}, 32'h0008);
    chk("t6_lap_hold", {16'd0, lap_digits}, 32'h0007);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t6_lap_clear", {16'd0, lap_digits}, 32'h0000);
`endif

    // Randomized run against the model
    sm_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) sm_lvl = ~sm_lvl;
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0), sm_lvl,
           2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
